// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one byte-wide UART transmitter among N valid/ready byte streams.
// Latency: grant and tx_en registered one cycle after an idle request; grant held until the owner's last byte drains.
// Backpressure: in_ready only toward the owner, and only while the transmitter is idle (tx_busy=0).
module uart_tx_arbiter #(
  parameter int N   = 4,
  parameter int IDW = $clog2(N)
) (
  input  logic           clk,
  input  logic           resetn,
  input  logic [N-1:0]   in_valid,
  input  logic [8*N-1:0] in_data,
  input  logic [N-1:0]   in_last,
  output logic [N-1:0]   in_ready,
  input  logic           tx_busy,
  output logic [7:0]     out_tx_data,
  output logic           out_tx_en,
  output logic [N-1:0]   out_grant,
  output logic           out_active,
  output logic [15:0]    out_msg_count
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SEND  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t         state_q, state_d;
  logic [IDW-1:0] owner_q, owner_d;
  logic [IDW-1:0] ptr_q, ptr_d;
  logic [IDW-1:0] win_idx, sel_idx;
  logic           win_found;
  logic           last_q, last_d;
  logic           take;
  logic           tx_en_d;
  logic [7:0]     tx_data_d;
  logic [N-1:0]   grant_d;
  logic [15:0]    msg_count_d;
  logic [7:0]     lane [N];

  always_comb begin
    for (int i = 0; i < N; i++) lane[i] = in_data[8*i +: 8];
  end

  // Search starts just past the previous winner so it gets lowest priority.
  always_comb begin : rr_search
    logic [IDW-1:0] cand;
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int k = 1; k <= N; k++) begin
      cand = IDW'((int'(ptr_q) + k) % N);
      if (!win_found && in_valid[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    ptr_d       = ptr_q;
    last_d      = last_q;
    tx_data_d   = out_tx_data;
    tx_en_d     = out_tx_en;
    grant_d     = out_grant;
    msg_count_d = out_msg_count;
    in_ready    = '0;
    take        = 1'b0;
    sel_idx     = owner_q;

    case (state_q)
      IDLE: begin
        if (!tx_busy && win_found) begin
          take             = 1'b1;
          sel_idx          = win_idx;
          owner_d          = win_idx;
          ptr_d            = win_idx;
          grant_d          = '0;
          grant_d[win_idx] = 1'b1;
        end
      end
      SEND: begin
        if (tx_busy) begin
          tx_en_d = 1'b0;
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        // Without a last byte the grant stays locked even if the owner stalls.
        if (!tx_busy) begin
          if (last_q) begin
            state_d     = IDLE;
            grant_d     = '0;
            msg_count_d = out_msg_count + 16'd1;
          end else if (in_valid[owner_q]) begin
            take = 1'b1;
          end
        end
      end
      default: begin
        state_d = IDLE;
        tx_en_d = 1'b0;
        grant_d = '0;
      end
    endcase

    if (take) begin
      in_ready[sel_idx] = 1'b1;
      tx_data_d         = lane[sel_idx];
      last_d            = in_last[sel_idx];
      tx_en_d           = 1'b1;
      state_d           = SEND;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q       <= IDLE;
      owner_q       <= '0;
      ptr_q         <= IDW'(N - 1);
      last_q        <= 1'b0;
      out_tx_data   <= '0;
      out_tx_en     <= 1'b0;
      out_grant     <= '0;
      out_msg_count <= '0;
    end else begin
      state_q       <= state_d;
      owner_q       <= owner_d;
      ptr_q         <= ptr_d;
      last_q        <= last_d;
      out_tx_data   <= tx_data_d;
      out_tx_en     <= tx_en_d;
      out_grant     <= grant_d;
      out_msg_count <= msg_count_d;
    end
  end

  assign out_active = (state_q != IDLE);

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: byte-stream sources and a transmitter model
// (busy rises one cycle after tx_en, stays high 10 cycles) driven from one initial block.
module tb_uart_tx_arbiter;
  localparam int N = 4;

  logic           clk = 1'b0;
  logic           resetn;
  logic [N-1:0]   in_valid;
  logic [8*N-1:0] in_data;
  logic [N-1:0]   in_last;
  logic [N-1:0]   in_ready;
  logic           tx_busy;
  logic [7:0]     out_tx_data;
  logic           out_tx_en;
  logic [N-1:0]   out_grant;
  logic           out_active;
  logic [15:0]    out_msg_count;

  uart_tx_arbiter #(.N(N)) dut (
    .clk(clk), .resetn(resetn),
    .in_valid(in_valid), .in_data(in_data), .in_last(in_last), .in_ready(in_ready),
    .tx_busy(tx_busy), .out_tx_data(out_tx_data), .out_tx_en(out_tx_en),
    .out_grant(out_grant), .out_active(out_active), .out_msg_count(out_msg_count)
  );

  always #5 clk = ~clk;

  logic [8:0]   msg [N][9];
  int           len [N];
  int           pos [N];
  bit           src_on [N];
  bit           hold [N];
  logic         model_busy;
  logic         force_busy;
  int           busy_cnt;
  logic [N-1:0] log_grant [$];
  logic [7:0]   log_data [$];
  logic [N-1:0] last_fire;
  int           vectors = 0;
  int           miscompares = 0;

  assign tx_busy = model_busy | force_busy;

  task automatic drive_lanes();
    for (int i = 0; i < N; i++) begin
      logic v;
      v = src_on[i] && !hold[i] && (pos[i] < len[i]);
      in_valid[i]       = v;
      in_data[8*i +: 8] = v ? msg[i][pos[i]][7:0] : 8'h00;
      in_last[i]        = v ? msg[i][pos[i]][8] : 1'b0;
    end
  endtask

  task automatic clear_src();
    for (int i = 0; i < N; i++) begin
      src_on[i] = 1'b0; hold[i] = 1'b0; len[i] = 0; pos[i] = 0;
    end
    drive_lanes();
  endtask

  task automatic set_byte(input int ln, input int idx, input logic lst, input logic [7:0] d);
    msg[ln][idx] = {lst, d};
    if (idx + 1 > len[ln]) len[ln] = idx + 1;
  endtask

  function automatic bit pending();
    pending = 1'b0;
    for (int i = 0; i < N; i++) if (src_on[i] && pos[i] < len[i]) pending = 1'b1;
  endfunction

  // One clock: sample at negedge, advance sources and transmitter model just after the edge.
  task automatic cyc();
    logic         en_s;
    logic [7:0]   d_s;
    logic [N-1:0] g_s;
    @(negedge clk);
    last_fire = in_valid & in_ready;
    en_s = out_tx_en; d_s = out_tx_data; g_s = out_grant;
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) if (last_fire[i]) pos[i]++;
    if (model_busy) begin
      busy_cnt--;
      if (busy_cnt == 0) model_busy = 1'b0;
    end else if (en_s) begin
      model_busy = 1'b1;
      busy_cnt   = 10;
      log_grant.push_back(g_s);
      log_data.push_back(d_s);
    end
    drive_lanes();
  endtask

  task automatic apply_reset();
    resetn = 1'b0;
    model_busy = 1'b0; busy_cnt = 0;
    log_grant.delete(); log_data.delete();
    repeat (2) @(posedge clk);
    #1 resetn = 1'b1;
    drive_lanes();
  endtask

  task automatic run_done(input int budget, output bit ok);
    int n;
    n = 0; ok = 1'b0;
    while (n < budget) begin
      if (!pending() && !out_active && !model_busy) begin ok = 1'b1; break; end
      cyc(); n++;
    end
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    #1;
    vectors++; if (out_tx_en !== 1'b0) begin miscompares++; $display("FAIL reset_tx_en got %b want 0", out_tx_en); end
    vectors++; if (out_grant !== 4'b0000) begin miscompares++; $display("FAIL reset_grant got %b want 0000", out_grant); end
    vectors++; if (out_tx_data !== 8'h00) begin miscompares++; $display("FAIL reset_tx_data got %h want 00", out_tx_data); end
    vectors++; if (out_msg_count !== 16'd0) begin miscompares++; $display("FAIL reset_msg_count got %0d want 0", out_msg_count); end
    vectors++; if (out_active !== 1'b0) begin miscompares++; $display("FAIL reset_active got %b want 0", out_active); end
    apply_reset();
    repeat (3) cyc();
    vectors++; if (out_active !== 1'b0 || out_tx_en !== 1'b0) begin miscompares++; $display("FAIL idle_no_req got active=%b en=%b want 0 0", out_active, out_tx_en); end
  endtask

  task automatic test_single();
    bit ok;
    clear_src();
    set_byte(2, 0, 1'b0, 8'h48); set_byte(2, 1, 1'b1, 8'h69); src_on[2] = 1'b1;
    apply_reset();
    #1;
    vectors++; if (in_ready !== 4'b0100) begin miscompares++; $display("FAIL single_ready got %b want 0100", in_ready); end
    cyc();
    vectors++; if (out_tx_en !== 1'b1 || out_grant !== 4'b0100 || out_tx_data !== 8'h48) begin
      miscompares++; $display("FAIL single_grant_latency got en=%b grant=%b data=%h want 1 0100 48", out_tx_en, out_grant, out_tx_data); end
    cyc();
    vectors++; if (out_tx_en !== 1'b1) begin miscompares++; $display("FAIL single_en_hold got %b want 1", out_tx_en); end
    cyc();
    vectors++; if (out_tx_en !== 1'b0 || out_active !== 1'b1) begin miscompares++; $display("FAIL single_en_fall got en=%b active=%b want 0 1", out_tx_en, out_active); end
    run_done(400, ok);
    vectors++; if (!ok) begin miscompares++; $display("FAIL single_timeout got done=0 want 1"); end
    vectors++; if (log_data.size() != 2) begin miscompares++; $display("FAIL single_bytes got %0d want 2", log_data.size()); end
    else begin
      vectors++; if (log_data[0] !== 8'h48 || log_data[1] !== 8'h69 || log_grant[0] !== 4'b0100 || log_grant[1] !== 4'b0100) begin
        miscompares++; $display("FAIL single_seq got %h/%b %h/%b want 48/0100 69/0100", log_data[0], log_grant[0], log_data[1], log_grant[1]); end
    end
    vectors++; if (out_msg_count !== 16'd1 || out_grant !== 4'b0000) begin
      miscompares++; $display("FAIL single_end got count=%0d grant=%b want 1 0000", out_msg_count, out_grant); end
  endtask

  task automatic test_contention();
    bit ok;
    int order [3];
    order = '{0, 1, 3};
    clear_src();
    for (int k = 0; k < 3; k++) begin
      for (int j = 0; j < 3; j++) set_byte(order[k], j, (j == 2), 8'(order[k] * 16 + j));
      src_on[order[k]] = 1'b1;
    end
    apply_reset();
    run_done(1000, ok);
    vectors++; if (!ok) begin miscompares++; $display("FAIL contention_timeout got done=0 want 1"); end
    vectors++; if (log_data.size() != 9) begin miscompares++; $display("FAIL contention_bytes got %0d want 9", log_data.size()); end
    for (int e = 0; e < 9 && e < log_data.size(); e++) begin
      logic [N-1:0] exp_g;
      logic [7:0]   exp_d;
      exp_g = '0; exp_g[order[e/3]] = 1'b1;
      exp_d = 8'(order[e/3] * 16 + e % 3);
      vectors++;
      if (log_grant[e] !== exp_g || log_data[e] !== exp_d) begin
        miscompares++; $display("FAIL contention_byte%0d got %b/%h want %b/%h", e, log_grant[e], log_data[e], exp_g, exp_d); end
    end
    vectors++; if (out_msg_count !== 16'd3) begin miscompares++; $display("FAIL contention_count got %0d want 3", out_msg_count); end
  endtask

  task automatic test_fairness();
    bit ok;
    clear_src();
    for (int j = 0; j < 3; j++) begin
      set_byte(0, j, 1'b1, 8'hA0 + 8'(j));
      set_byte(1, j, 1'b1, 8'hB0 + 8'(j));
    end
    src_on[0] = 1'b1; src_on[1] = 1'b1;
    apply_reset();
    run_done(1000, ok);
    vectors++; if (!ok) begin miscompares++; $display("FAIL fair_timeout got done=0 want 1"); end
    vectors++; if (log_data.size() != 6) begin miscompares++; $display("FAIL fair_bytes got %0d want 6", log_data.size()); end
    for (int e = 0; e < 6 && e < log_data.size(); e++) begin
      logic [N-1:0] exp_g;
      logic [7:0]   exp_d;
      exp_g = '0; exp_g[e % 2] = 1'b1;
      exp_d = ((e % 2) == 0 ? 8'hA0 : 8'hB0) + 8'(e / 2);
      vectors++;
      if (log_grant[e] !== exp_g || log_data[e] !== exp_d) begin
        miscompares++; $display("FAIL fair_msg%0d got %b/%h want %b/%h", e, log_grant[e], log_data[e], exp_g, exp_d); end
    end
    vectors++; if (out_msg_count !== 16'd6) begin miscompares++; $display("FAIL fair_count got %0d want 6", out_msg_count); end
  endtask

  task automatic test_lock_stall();
    bit ok;
    bit got;
    clear_src();
    set_byte(1, 0, 1'b0, 8'h51); set_byte(1, 1, 1'b1, 8'h52); src_on[1] = 1'b1;
    set_byte(0, 0, 1'b1, 8'h05);
    apply_reset();
    got = 1'b0;
    for (int c = 0; c < 10 && !got; c++) begin
      cyc();
      if (last_fire[1]) got = 1'b1;
    end
    vectors++; if (!got) begin miscompares++; $display("FAIL stall_first_byte got accepted=0 want 1"); end
    hold[1] = 1'b1; src_on[0] = 1'b1;
    drive_lanes();
    for (int c = 0; c < 20; c++) begin
      cyc();
      vectors++; if (out_grant !== 4'b0010) begin miscompares++; $display("FAIL stall_grant_c%0d got %b want 0010", c, out_grant); end
      vectors++; if (in_ready[0] !== 1'b0) begin miscompares++; $display("FAIL stall_ready0_c%0d got %b want 0", c, in_ready[0]); end
    end
    hold[1] = 1'b0;
    drive_lanes();
    run_done(400, ok);
    vectors++; if (!ok) begin miscompares++; $display("FAIL stall_timeout got done=0 want 1"); end
    vectors++; if (log_data.size() != 3) begin miscompares++; $display("FAIL stall_bytes got %0d want 3", log_data.size()); end
    else begin
      vectors++;
      if (log_grant[0] !== 4'b0010 || log_data[0] !== 8'h51 || log_grant[1] !== 4'b0010 || log_data[1] !== 8'h52 ||
          log_grant[2] !== 4'b0001 || log_data[2] !== 8'h05) begin
        miscompares++; $display("FAIL stall_seq got %b/%h %b/%h %b/%h want 0010/51 0010/52 0001/05",
                               log_grant[0], log_data[0], log_grant[1], log_data[1], log_grant[2], log_data[2]); end
    end
    vectors++; if (out_msg_count !== 16'd2) begin miscompares++; $display("FAIL stall_count got %0d want 2", out_msg_count); end
  endtask

  task automatic test_busy_idle();
    bit ok;
    clear_src();
    set_byte(3, 0, 1'b1, 8'hC3); src_on[3] = 1'b1;
    force_busy = 1'b1;
    apply_reset();
    for (int c = 0; c < 5; c++) begin
      cyc();
      vectors++; if (out_tx_en !== 1'b0 || out_grant !== 4'b0000 || in_ready !== 4'b0000) begin
        miscompares++; $display("FAIL busy_hold_c%0d got en=%b grant=%b ready=%b want 0 0000 0000", c, out_tx_en, out_grant, in_ready); end
    end
    force_busy = 1'b0;
    #1;
    vectors++; if (in_ready !== 4'b1000) begin miscompares++; $display("FAIL busy_release_ready got %b want 1000", in_ready); end
    cyc();
    vectors++; if (out_grant !== 4'b1000 || out_tx_en !== 1'b1) begin
      miscompares++; $display("FAIL busy_release_grant got grant=%b en=%b want 1000 1", out_grant, out_tx_en); end
    run_done(200, ok);
    vectors++; if (!ok || log_data.size() != 1 || out_msg_count !== 16'd1) begin
      miscompares++; $display("FAIL busy_done got ok=%b bytes=%0d count=%0d want 1 1 1", ok, log_data.size(), out_msg_count); end
  endtask

  task automatic test_reset_mid();
    bit ok;
    bit got;
    clear_src();
    set_byte(0, 0, 1'b1, 8'h0A); src_on[0] = 1'b1;
    apply_reset();
    run_done(200, ok);
    vectors++; if (!ok || out_msg_count !== 16'd1) begin
      miscompares++; $display("FAIL mid_pre got ok=%b count=%0d want 1 1", ok, out_msg_count); end
    set_byte(0, 0, 1'b1, 8'h0B); pos[0] = 0;
    set_byte(3, 0, 1'b0, 8'h3A); set_byte(3, 1, 1'b1, 8'h3B); src_on[3] = 1'b1;
    drive_lanes();
    got = 1'b0;
    for (int c = 0; c < 5 && !got; c++) begin
      cyc();
      if (out_tx_en === 1'b1) got = 1'b1;
    end
    vectors++; if (!got || out_grant !== 4'b1000) begin
      miscompares++; $display("FAIL mid_send got en=%b grant=%b want 1 1000", got, out_grant); end
    #1 resetn = 1'b0;
    #1;
    vectors++; if (out_tx_en !== 1'b0 || out_grant !== 4'b0000 || out_msg_count !== 16'd0 || out_active !== 1'b0) begin
      miscompares++; $display("FAIL mid_async_clear got en=%b grant=%b count=%0d active=%b want 0 0000 0 0",
                             out_tx_en, out_grant, out_msg_count, out_active); end
    pos[3] = 0;
    model_busy = 1'b0; busy_cnt = 0;
    log_grant.delete(); log_data.delete();
    @(posedge clk);
    #1 resetn = 1'b1;
    drive_lanes();
    cyc();
    vectors++; if (out_grant !== 4'b0001) begin miscompares++; $display("FAIL mid_first_after got %b want 0001", out_grant); end
    run_done(400, ok);
    vectors++; if (!ok || log_data.size() != 3) begin
      miscompares++; $display("FAIL mid_done got ok=%b bytes=%0d want 1 3", ok, log_data.size()); end
    else begin
      vectors++;
      if (log_grant[0] !== 4'b0001 || log_data[0] !== 8'h0B || log_grant[1] !== 4'b1000 || log_data[1] !== 8'h3A ||
          log_grant[2] !== 4'b1000 || log_data[2] !== 8'h3B) begin
        miscompares++; $display("FAIL mid_seq got %b/%h %b/%h %b/%h want 0001/0b 1000/3a 1000/3b",
                               log_grant[0], log_data[0], log_grant[1], log_data[1], log_grant[2], log_data[2]); end
    end
    vectors++; if (out_msg_count !== 16'd2) begin miscompares++; $display("FAIL mid_count got %0d want 2", out_msg_count); end
  endtask

  initial begin
    resetn = 1'b0;
    in_valid = '0; in_data = '0; in_last = '0;
    force_busy = 1'b0; model_busy = 1'b0; busy_cnt = 0; last_fire = '0;
    clear_src();
    test_reset();
    test_single();
    test_contention();
    test_fairness();
    test_lock_stall();
    test_busy_idle();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
